// File: rtl/cpf_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cpf_frame_sequencer
// Brief    : Serialises one status/control/address/payload frame per handshake
//            into the CP_F encoder byte stream, with K28.5 idle fill, CRC-slot
//            and CRC-reset strobes. Optional EOF cycle: CPF_SEQ_EOF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module cpf_frame_sequencer #(
    parameter int         DATA_BYTES = 4,
    parameter int         MIN_IDLE   = 2,
    parameter logic [7:0] IDLE_CHAR  = 8'hBC
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    frame_valid,
    output logic                    frame_ready,
    input  logic [7:0]              status_in,
    input  logic [7:0]              control_in,
    input  logic [7:0]              address_in,
    input  logic [8*DATA_BYTES-1:0] payload_in,
    output logic [7:0]              byte_out,
    output logic                    is_control_byte,
    output logic                    is_crc_byte,
    output logic                    crc_reset,
    output logic                    busy,
    output logic                    frame_done
);

    localparam logic [3:0] c_st_idle    = 4'd0;
    localparam logic [3:0] c_st_sof     = 4'd1;
    localparam logic [3:0] c_st_status  = 4'd2;
    localparam logic [3:0] c_st_control = 4'd3;
    localparam logic [3:0] c_st_addr    = 4'd4;
    localparam logic [3:0] c_st_data    = 4'd5;
    localparam logic [3:0] c_st_crc     = 4'd6;
    localparam logic [3:0] c_st_eof     = 4'd7;
    localparam logic [3:0] c_st_gap     = 4'd8;

    localparam int         c_pw         = 8 * DATA_BYTES;
    localparam logic [7:0] c_eof_char   = 8'hFD;
    localparam logic [5:0] c_last_idx   = 6'(DATA_BYTES - 1);
    localparam int         c_gap_init   = (MIN_IDLE > 0) ? MIN_IDLE - 1 : 0;
    localparam logic [7:0] c_gap_load   = 8'(c_gap_init);

    logic [3:0]      r_state;
    logic [7:0]      r_status;
    logic [7:0]      r_control;
    logic [7:0]      r_address;
    logic [c_pw-1:0] r_payload;
    logic [5:0]      r_idx;
    logic [7:0]      r_gap_cnt;
    logic [7:0]      r_byte;
    logic            r_is_control;
    logic            r_is_crc;
    logic            r_crc_reset;
    logic            r_busy;
    logic            r_frame_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_st_idle;
            r_status     <= 8'h00;
            r_control    <= 8'h00;
            r_address    <= 8'h00;
            r_payload    <= '0;
            r_idx        <= 6'd0;
            r_gap_cnt    <= 8'd0;
            r_byte       <= IDLE_CHAR;
            r_is_control <= 1'b1;
            r_is_crc     <= 1'b0;
            r_crc_reset  <= 1'b1;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (frame_valid) begin
                        r_status     <= status_in;
                        r_control    <= control_in;
                        r_address    <= address_in;
                        r_payload    <= payload_in;
                        r_state      <= c_st_sof;
                        r_byte       <= IDLE_CHAR;
                        r_is_control <= 1'b1;
                        r_crc_reset  <= 1'b1;
                        r_busy       <= 1'b1;
                    end
                end
                c_st_sof: begin
                    r_state      <= c_st_status;
                    r_byte       <= r_status;
                    r_is_control <= 1'b0;
                    r_crc_reset  <= 1'b0;
                end
                c_st_status: begin
                    r_state <= c_st_control;
                    r_byte  <= r_control;
                end
                c_st_control: begin
                    r_state <= c_st_addr;
                    r_byte  <= r_address;
                end
                c_st_addr: begin
                    // Payload leaves MSB byte first by shifting the capture left.
                    r_state   <= c_st_data;
                    r_byte    <= r_payload[c_pw-1 -: 8];
                    r_payload <= r_payload << 8;
                    r_idx     <= 6'd0;
                end
                c_st_data: begin
                    if (r_idx == c_last_idx) begin
                        r_state  <= c_st_crc;
                        r_byte   <= 8'h00;
                        r_is_crc <= 1'b1;
                    end else begin
                        r_byte    <= r_payload[c_pw-1 -: 8];
                        r_payload <= r_payload << 8;
                        r_idx     <= r_idx + 6'd1;
                    end
                end
`ifdef CPF_SEQ_EOF_EN
                c_st_crc: begin
                    r_state      <= c_st_eof;
                    r_byte       <= c_eof_char;
                    r_is_control <= 1'b1;
                    r_is_crc     <= 1'b0;
                    r_crc_reset  <= 1'b1;
                end
                c_st_eof: begin
                    r_byte       <= IDLE_CHAR;
                    r_is_control <= 1'b1;
                    r_crc_reset  <= 1'b1;
                    r_busy       <= 1'b0;
                    r_frame_done <= 1'b1;
                    if (MIN_IDLE == 0) begin
                        r_state <= c_st_idle;
                    end else begin
                        r_state   <= c_st_gap;
                        r_gap_cnt <= c_gap_load;
                    end
                end
`else
                c_st_crc: begin
                    r_byte       <= IDLE_CHAR;
                    r_is_control <= 1'b1;
                    r_is_crc     <= 1'b0;
                    r_crc_reset  <= 1'b1;
                    r_busy       <= 1'b0;
                    r_frame_done <= 1'b1;
                    if (MIN_IDLE == 0) begin
                        r_state <= c_st_idle;
                    end else begin
                        r_state   <= c_st_gap;
                        r_gap_cnt <= c_gap_load;
                    end
                end
`endif
                c_st_gap: begin
                    if (r_gap_cnt == 8'd0) begin
                        r_state <= c_st_idle;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 8'd1;
                    end
                end
                default: begin
                    r_state      <= c_st_idle;
                    r_byte       <= IDLE_CHAR;
                    r_is_control <= 1'b1;
                    r_is_crc     <= 1'b0;
                    r_crc_reset  <= 1'b1;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    assign frame_ready     = (r_state == c_st_idle);
    assign byte_out        = r_byte;
    assign is_control_byte = r_is_control;
    assign is_crc_byte     = r_is_crc;
    assign crc_reset       = r_crc_reset;
    assign busy            = r_busy;
    assign frame_done      = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_cpf_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpf_frame_sequencer
// Brief    : Queue-based stream model for two sequencer configurations
//            (4 bytes/2 idle and 1 byte/0 idle); follows CPF_SEQ_EOF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpf_frame_sequencer;

`ifdef CPF_SEQ_EOF_EN
    localparam int c_eof = 1;
`else
    localparam int c_eof = 0;
`endif

    typedef struct packed {
        logic [7:0] b;
        logic       k;
        logic       crc;
        logic       crcr;
        logic       busy;
        logic       last;
    } ent_t;

    localparam ent_t c_idle_e = '{8'hBC, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    localparam ent_t c_sof_e  = '{8'hBC, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    logic         clk;
    logic         reset;
    logic [1:0]   fv;
    logic [15:0]  st;
    logic [15:0]  ct;
    logic [15:0]  ad;
    logic [511:0] pl [2];
    logic [1:0]   d_ready;
    logic [15:0]  d_byte;
    logic [1:0]   d_k;
    logic [1:0]   d_crc;
    logic [1:0]   d_crcr;
    logic [1:0]   d_busy;
    logic [1:0]   d_done;
    logic         chk_en;
    int           checks;
    int           errors;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int inst, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s inst%0d actual %0h required %0h at %0t", nm, inst, act, req, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_cfg
        localparam int DB = (g == 0) ? 4 : 1;
        localparam int MI = (g == 0) ? 2 : 0;

        ent_t q[$];
        ent_t exp_e;
        logic exp_ready;
        logic exp_done;

        cpf_frame_sequencer #(
            .DATA_BYTES (DB),
            .MIN_IDLE   (MI),
            .IDLE_CHAR  (8'hBC)
        ) u_dut (
            .clk             (clk),
            .reset           (reset),
            .frame_valid     (fv[g]),
            .frame_ready     (d_ready[g]),
            .status_in       (st[8*g +: 8]),
            .control_in      (ct[8*g +: 8]),
            .address_in      (ad[8*g +: 8]),
            .payload_in      (pl[g][8*DB-1:0]),
            .byte_out        (d_byte[8*g +: 8]),
            .is_control_byte (d_k[g]),
            .is_crc_byte     (d_crc[g]),
            .crc_reset       (d_crcr[g]),
            .busy            (d_busy[g]),
            .frame_done      (d_done[g])
        );

        // Whole frame is queued at acceptance; an empty queue means IDLE.
        task automatic push_frame(input logic [7:0] s, input logic [7:0] c,
                                  input logic [7:0] a, input logic [511:0] p);
            q.push_back(c_sof_e);
            q.push_back('{s, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
            q.push_back('{c, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
            q.push_back('{a, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
            for (int i = 0; i < DB; i++)
                q.push_back('{p[8*(DB-1-i) +: 8], 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
`ifdef CPF_SEQ_EOF_EN
            q.push_back('{8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
            q.push_back('{8'hFD, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1});
`else
            q.push_back('{8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1});
`endif
            for (int i = 0; i < MI; i++)
                q.push_back(c_idle_e);
        endtask

        always @(posedge clk) begin
            if (reset) begin
                q.delete();
                exp_e     <= c_idle_e;
                exp_ready <= 1'b1;
                exp_done  <= 1'b0;
            end else begin
                if (exp_ready && fv[g])
                    push_frame(st[8*g +: 8], ct[8*g +: 8], ad[8*g +: 8], pl[g]);
                exp_done <= exp_e.last;
                if (q.size() != 0) begin
                    exp_e     <= q.pop_front();
                    exp_ready <= 1'b0;
                end else begin
                    exp_e     <= c_idle_e;
                    exp_ready <= 1'b1;
                end
            end
        end

        always @(negedge clk) begin
            if (chk_en) begin
                chk("byte_out", g, 32'(d_byte[8*g +: 8]), 32'(exp_e.b));
                chk("is_control_byte", g, 32'(d_k[g]), 32'(exp_e.k));
                chk("is_crc_byte", g, 32'(d_crc[g]), 32'(exp_e.crc));
                chk("crc_reset", g, 32'(d_crcr[g]), 32'(exp_e.crcr));
                chk("busy", g, 32'(d_busy[g]), 32'(exp_e.busy));
                chk("frame_done", g, 32'(d_done[g]), 32'(exp_done));
                chk("frame_ready", g, 32'(d_ready[g]), 32'(exp_ready));
            end
        end
    end

    logic [7:0] cap_b    [12];
    logic       cap_k    [12];
    logic       cap_crc  [12];
    logic       cap_done [12];
    logic [7:0] lit_seq  [8];
    int         prev_busy [2];
    int         last_sof  [2];
    int         sofs      [2];
    int         dones     [2];
    int         commas    [2];
    int         seen_crc  [2];
    int         exp_period[2];
    int         exp_commas[2];
    int         cnt;

    task automatic rand_fields();
        st    = 16'($urandom);
        ct    = 16'($urandom);
        ad    = 16'($urandom);
        pl[0] = {16{$urandom}};
        pl[1] = {16{$urandom}};
    endtask

    initial begin
        checks = 0;
        errors = 0;
        chk_en = 1'b0;
        reset  = 1'b1;
        fv     = 2'b00;
        st     = '0;
        ct     = '0;
        ad     = '0;
        pl[0]  = '0;
        pl[1]  = '0;
        lit_seq = '{8'hBC, 8'h01, 8'h20, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        exp_period = '{12 + c_eof, 7 + c_eof};
        exp_commas = '{3, 1};

        @(negedge clk);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset byte_out", 0, 32'(d_byte[7:0]), 32'h0BC);
        chk("reset is_control_byte", 0, 32'(d_k[0]), 32'd1);
        chk("reset crc_reset", 0, 32'(d_crcr[0]), 32'd1);
        chk("reset frame_ready", 0, 32'(d_ready[0]), 32'd1);
        chk("reset busy", 0, 32'(d_busy[0]), 32'd0);

        // Directed frame on the 4-byte configuration.
        reset    = 1'b0;
        fv[0]    = 1'b1;
        st[7:0]  = 8'h01;
        ct[7:0]  = 8'h20;
        ad[7:0]  = 8'h10;
        pl[0]    = 512'hDEADBEEF;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            fv[0]       = 1'b0;
            cap_b[i]    = d_byte[7:0];
            cap_k[i]    = d_k[0];
            cap_crc[i]  = d_crc[0];
            cap_done[i] = d_done[0];
        end
        for (int i = 0; i < 8; i++)
            chk("frame byte", i, 32'(cap_b[i]), 32'(lit_seq[i]));
        chk("sof is K", 0, 32'(cap_k[0]), 32'd1);
        chk("status not K", 0, 32'(cap_k[1]), 32'd0);
        chk("crc slot byte", 0, 32'(cap_b[8]), 32'h0);
        chk("crc slot flag", 0, 32'(cap_crc[8]), 32'd1);
        chk("last payload not crc", 0, 32'(cap_crc[7]), 32'd0);
        chk("done after slot", 0, 32'(cap_done[9 + c_eof]), 32'd1);
        chk("no early done", 0, 32'(cap_done[8 + c_eof]), 32'd0);
`ifdef CPF_SEQ_EOF_EN
        chk("eof byte", 0, 32'(cap_b[9]), 32'h0FD);
        chk("eof is K", 0, 32'(cap_k[9]), 32'd1);
`endif
        repeat (10) @(negedge clk);

        // Back-to-back with frame_valid held on both configurations.
        for (int i = 0; i < 2; i++) begin
            prev_busy[i] = 0;
            last_sof[i]  = -1;
            sofs[i]      = 0;
            dones[i]     = 0;
            commas[i]    = 0;
            seen_crc[i]  = 0;
        end
        for (int cyc = 0; cyc < 90; cyc++) begin
            fv = (cyc < 60) ? 2'b11 : 2'b00;
            rand_fields();
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (d_busy[i] && prev_busy[i] == 0) begin
                    if (last_sof[i] >= 0)
                        chk("sof period", i, 32'(cyc - last_sof[i]), 32'(exp_period[i]));
                    if (seen_crc[i] != 0)
                        chk("commas between frames", i, 32'(commas[i]), 32'(exp_commas[i]));
                    last_sof[i] = cyc;
                    sofs[i]++;
                    seen_crc[i] = 0;
                end
                if (d_crc[i]) begin
                    seen_crc[i] = 1;
                    commas[i]   = 0;
                end else if (seen_crc[i] != 0 && d_byte[8*i +: 8] == 8'hBC && d_k[i])
                    commas[i]++;
                if (d_done[i])
                    dones[i]++;
                prev_busy[i] = int'(d_busy[i]);
            end
        end
        for (int i = 0; i < 2; i++) begin
            chk("done per frame", i, 32'(dones[i]), 32'(sofs[i]));
            chk("several frames", i, 32'(sofs[i] > 2), 32'd1);
        end

        // Reset sampled mid-payload aborts the frame without frame_done.
        fv[0] = 1'b1;
        rand_fields();
        repeat (6) begin
            @(negedge clk);
            fv[0] = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort byte_out", 0, 32'(d_byte[7:0]), 32'h0BC);
        chk("abort crc_reset", 0, 32'(d_crcr[0]), 32'd1);
        chk("abort busy", 0, 32'(d_busy[0]), 32'd0);
        cnt = int'(d_done[0]);
        repeat (12) begin
            @(negedge clk);
            cnt += int'(d_done[0]);
        end
        chk("no done after abort", 0, 32'(cnt), 32'd0);
        fv[0] = 1'b1;
        rand_fields();
        cnt = 0;
        repeat (16) begin
            @(negedge clk);
            fv[0] = 1'b0;
            cnt += int'(d_done[0]);
        end
        chk("frame after abort done", 0, 32'(cnt), 32'd1);

        // Randomized traffic with occasional resets.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            fv[0] = ($urandom_range(0, 3) != 0);
            fv[1] = ($urandom_range(0, 2) == 0);
            reset = ($urandom_range(0, 199) == 0);
            rand_fields();
            @(negedge clk);
        end
        reset = 1'b0;
        fv    = 2'b00;
        repeat (20) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
